// File: rtl/wb_trace_buffer_if.sv
// rtl/wb_trace_buffer_if.sv - write-back capture and trace drain signals of wb_trace_buffer
interface wb_trace_buffer_if #(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int IDX_W = 5
);
  logic             wb_valid;
  logic [PC_W-1:0]  wb_pc;
  logic [IDX_W-1:0] wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic             wb_regwrite;

  logic             out_valid;
  logic             out_ready;
  logic [PC_W-1:0]  out_pc;
  logic [IDX_W-1:0] out_rd;
  logic [XLEN-1:0]  out_data;
  logic             out_rw;

  modport master (
    output wb_valid, wb_pc, wb_rd, wb_data, wb_regwrite, out_ready,
    input  out_valid, out_pc, out_rd, out_data, out_rw
  );

  modport slave (
    input  wb_valid, wb_pc, wb_rd, wb_data, wb_regwrite, out_ready,
    output out_valid, out_pc, out_rd, out_data, out_rw
  );
endinterface

// File: rtl/wb_trace_buffer.sv
// rtl/wb_trace_buffer.sv - MEM/WB commit trace FWFT FIFO with masked watchpoint halt
// Optional feature macro: TRACE_FILTER_X0_EN (ignore x0 commits for capture and watch).
module wb_trace_buffer #(
  parameter int XLEN   = 32,
  parameter int PC_W   = 32,
  parameter int IDX_W  = 5,
  parameter int DEPTH  = 16,
  parameter int DROP_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  wb_trace_buffer_if.slave           bus,
  input  logic                       cap_all,
  input  logic                       clear,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_cnt,
  input  logic                       watch_en,
  input  logic [IDX_W-1:0]           watch_rd,
  input  logic [XLEN-1:0]            watch_data,
  input  logic [XLEN-1:0]            watch_mask,
  output logic                       halt_req,
  input  logic                       halt_ack
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int ENT_W = PC_W + IDX_W + XLEN + 1;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic qualified;
  logic push;
  logic pop;
  logic drop;
  logic hit;

  always_comb begin
    qualified = bus.wb_valid & (cap_all | bus.wb_regwrite);
    hit = bus.wb_valid & bus.wb_regwrite & watch_en & (bus.wb_rd == watch_rd) &
          (((bus.wb_data ^ watch_data) & watch_mask) == '0);
`ifdef TRACE_FILTER_X0_EN
    qualified = qualified & (bus.wb_rd != '0);
    hit       = hit & (watch_rd != '0);
`else
`endif
  end

  assign full          = (count == CNT_W'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign pop           = bus.out_valid & bus.out_ready;
  assign push          = qualified & (~full | pop);
  assign drop          = qualified & full & ~pop;

  assign {bus.out_pc, bus.out_rd, bus.out_data, bus.out_rw} = mem[rd_ptr];

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.wb_pc, bus.wb_rd, bus.wb_data, bus.wb_regwrite};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + DROP_W'(1);
        end
      end
    end
  end

  // A fresh hit outranks an acknowledge landing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_req <= 1'b0;
    end else if (hit) begin
      halt_req <= 1'b1;
    end else if (halt_ack) begin
      halt_req <= 1'b0;
    end
  end
endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb/tb_wb_trace_buffer.sv - directed self-checking bench for wb_trace_buffer
module tb_wb_trace_buffer;
  logic        clk = 1'b0;
  logic        rst;
  logic        cap_all;
  logic        clear;
  logic [4:0]  count;
  logic        full;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic        watch_en;
  logic [4:0]  watch_rd;
  logic [31:0] watch_data;
  logic [31:0] watch_mask;
  logic        halt_req;
  logic        halt_ack;

  int vectors = 0;
  int miscompares = 0;

  wb_trace_buffer_if #(.XLEN(32), .PC_W(32), .IDX_W(5)) bus ();

  wb_trace_buffer #(
    .XLEN(32), .PC_W(32), .IDX_W(5), .DEPTH(16), .DROP_W(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .cap_all    (cap_all),
    .clear      (clear),
    .count      (count),
    .full       (full),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .watch_en   (watch_en),
    .watch_rd   (watch_rd),
    .watch_data (watch_data),
    .watch_mask (watch_mask),
    .halt_req   (halt_req),
    .halt_ack   (halt_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic commit(input logic [31:0] pc, input logic [4:0] rd,
                        input logic [31:0] data, input logic rw);
    bus.wb_valid    = 1'b1;
    bus.wb_pc       = pc;
    bus.wb_rd       = rd;
    bus.wb_data     = data;
    bus.wb_regwrite = rw;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; cap_all = 1'b0;
    watch_en = 1'b0; watch_rd = '0; watch_data = '0; watch_mask = '0; halt_ack = 1'b0;
    bus.wb_valid = 1'b0; bus.wb_pc = '0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.wb_regwrite = 1'b0; bus.out_ready = 1'b0;

    // reset state
    tick(); tick();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_halt", 64'(halt_req), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    rst = 1'b0;

    // three commits, then in-order drain
    commit(32'd0, 5'd1, 32'd5, 1'b1); tick();
    check("fwft_valid_1", 64'(bus.out_valid), 64'd1);
    check("fwft_pc_1", 64'(bus.out_pc), 64'd0);
    commit(32'd4, 5'd2, 32'd7, 1'b1); tick();
    commit(32'd8, 5'd3, 32'd9, 1'b1); tick();
    bus.wb_valid = 1'b0;
    check("t2_count3", 64'(count), 64'd3);
    tick();
    check("t2_hold_pc", 64'(bus.out_pc), 64'd0);
    bus.out_ready = 1'b1;
    check("t2_pop0_pc", 64'(bus.out_pc), 64'd0);
    check("t2_pop0_rd", 64'(bus.out_rd), 64'd1);
    check("t2_pop0_data", 64'(bus.out_data), 64'd5);
    tick();
    check("t2_pop1_pc", 64'(bus.out_pc), 64'd4);
    check("t2_pop1_data", 64'(bus.out_data), 64'd7);
    tick();
    check("t2_pop2_pc", 64'(bus.out_pc), 64'd8);
    check("t2_pop2_rd", 64'(bus.out_rd), 64'd3);
    tick();
    check("t2_count0", 64'(count), 64'd0);
    check("t2_empty", 64'(bus.out_valid), 64'd0);
    tick();
    check("pop_empty_count", 64'(count), 64'd0);
    bus.out_ready = 1'b0;

    // capture filter
    cap_all = 1'b0;
    commit(32'h20, 5'd4, 32'd1, 1'b0); tick();
    bus.wb_valid = 1'b0;
    check("t6_store_skip", 64'(count), 64'd0);
    cap_all = 1'b1;
    commit(32'h24, 5'd4, 32'd1, 1'b0); tick();
    bus.wb_valid = 1'b0;
    check("capall_count", 64'(count), 64'd1);
    check("capall_rw", 64'(bus.out_rw), 64'd0);
    cap_all = 1'b0;
    commit(32'h28, 5'd0, 32'd7, 1'b1); tick();
    bus.wb_valid = 1'b0;
`ifdef TRACE_FILTER_X0_EN
    check("x0_count", 64'(count), 64'd1);
`else
    check("x0_count", 64'(count), 64'd2);
`endif
    clear = 1'b1;
    commit(32'h2C, 5'd6, 32'd3, 1'b1); tick();
    clear = 1'b0; bus.wb_valid = 1'b0;
    check("clear_push_count", 64'(count), 64'd0);
    check("clear_push_drop", 64'(drop_cnt), 64'd0);
    check("clear_push_valid", 64'(bus.out_valid), 64'd0);

    // overflow with 20 commits
    for (int i = 0; i < 20; i++) begin
      commit(32'(i * 4), 5'(i + 1), 32'(i * 3 + 100), 1'b1);
      tick();
      if (i == 15) begin
        check("t3_full_at16", 64'(full), 64'd1);
        check("t3_no_ovf_at16", 64'(overflow), 64'd0);
      end
    end
    bus.wb_valid = 1'b0;
    check("t3_full", 64'(full), 64'd1);
    check("t3_count", 64'(count), 64'd16);
    check("t3_overflow", 64'(overflow), 64'd1);
    check("t3_drop", 64'(drop_cnt), 64'd4);
    check("t3_head", 64'(bus.out_pc), 64'd0);

    // full with simultaneous push and pop
    bus.out_ready = 1'b1;
    commit(32'h1000, 5'd9, 32'hABCD, 1'b1); tick();
    bus.wb_valid = 1'b0; bus.out_ready = 1'b0;
    check("t4_count", 64'(count), 64'd16);
    check("t4_drop", 64'(drop_cnt), 64'd4);
    check("t4_head", 64'(bus.out_pc), 64'd4);
    bus.out_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      check("drain_pc", 64'(bus.out_pc), 64'(i * 4));
      check("drain_data", 64'(bus.out_data), 64'(i * 3 + 100));
      tick();
    end
    check("drain_last_pc", 64'(bus.out_pc), 64'h1000);
    check("drain_last_data", 64'(bus.out_data), 64'hABCD);
    tick();
    check("drain_count0", 64'(count), 64'd0);
    bus.out_ready = 1'b0;

    // drop counter saturation
    clear = 1'b1; tick(); clear = 1'b0;
    commit(32'h40, 5'd7, 32'd1, 1'b1);
    for (int i = 0; i < 276; i++) tick();
    bus.wb_valid = 1'b0;
    check("sat_drop", 64'(drop_cnt), 64'd255);
    check("sat_count", 64'(count), 64'd16);
    clear = 1'b1; tick(); clear = 1'b0;
    check("clr_overflow", 64'(overflow), 64'd0);
    check("clr_drop", 64'(drop_cnt), 64'd0);
    check("clr_count", 64'(count), 64'd0);

    // watchpoint
    watch_en = 1'b1; watch_rd = 5'd5; watch_data = 32'h40; watch_mask = 32'hF0;
    commit(32'h50, 5'd5, 32'h12345648, 1'b1); tick();
    bus.wb_valid = 1'b0;
    check("t5_hit", 64'(halt_req), 64'd1);
    tick();
    check("t5_held", 64'(halt_req), 64'd1);
    clear = 1'b1; tick(); clear = 1'b0;
    check("clear_keeps_halt", 64'(halt_req), 64'd1);
    halt_ack = 1'b1; tick(); halt_ack = 1'b0;
    check("t5_ack", 64'(halt_req), 64'd0);
    commit(32'h54, 5'd5, 32'h30, 1'b1); tick();
    check("t5_nohit", 64'(halt_req), 64'd0);
    commit(32'h58, 5'd6, 32'h40, 1'b1); tick();
    check("rd_mismatch", 64'(halt_req), 64'd0);
    commit(32'h5C, 5'd5, 32'h40, 1'b0); tick();
    check("norw_nohit", 64'(halt_req), 64'd0);
    commit(32'h60, 5'd5, 32'h4F, 1'b1); tick();
    check("hit2", 64'(halt_req), 64'd1);
    halt_ack = 1'b1;
    commit(32'h64, 5'd5, 32'h40, 1'b1); tick();
    halt_ack = 1'b0; bus.wb_valid = 1'b0;
    check("ack_vs_hit", 64'(halt_req), 64'd1);

    // reset mid-drain
    check("pre_rst_count", 64'(count), 64'd4);
    bus.out_ready = 1'b1; rst = 1'b1; tick(); rst = 1'b0; bus.out_ready = 1'b0;
    check("rst2_count", 64'(count), 64'd0);
    check("rst2_halt", 64'(halt_req), 64'd0);
    check("rst2_valid", 64'(bus.out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
